// File: rtl/gamma_pkg.sv
// Shared constants and FSM state type for the gamma LUT controller.
package gamma_pkg;

    localparam int PIX_W_DEFAULT = 8;
    localparam int LUT_DEPTH     = 2**PIX_W_DEFAULT;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

endpackage

// File: rtl/gamma_lut_bank.sv
// Two-bank LUT storage: one write port with per-bank enable mask, three async read ports.
module gamma_lut_bank
    import gamma_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEFAULT
) (
    input  logic             clk,
    input  logic [1:0]       wr_en,
    input  logic [PIX_W-1:0] wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             rd_bank,
    input  logic [PIX_W-1:0] rd_addr_r,
    input  logic [PIX_W-1:0] rd_addr_g,
    input  logic [PIX_W-1:0] rd_addr_b,
    output logic [PIX_W-1:0] rd_data_r,
    output logic [PIX_W-1:0] rd_data_g,
    output logic [PIX_W-1:0] rd_data_b
);

    localparam int DEPTH = 2**PIX_W;

    logic [PIX_W-1:0] bank0 [DEPTH];
    logic [PIX_W-1:0] bank1 [DEPTH];

    // wr_en bit n selects bank n; both set during table initialisation
    always_ff @(posedge clk) begin
        if (wr_en[0]) bank0[wr_addr] <= wr_data;
        if (wr_en[1]) bank1[wr_addr] <= wr_data;
    end

    assign rd_data_r = rd_bank ? bank1[rd_addr_r] : bank0[rd_addr_r];
    assign rd_data_g = rd_bank ? bank1[rd_addr_g] : bank0[rd_addr_g];
    assign rd_data_b = rd_bank ? bank1[rd_addr_b] : bank0[rd_addr_b];

endmodule

// File: rtl/gamma_lut_ctrl.sv
// Per-channel gamma LUT on a pixel stream with double-buffered tables swapped at start of frame.
// Macro GAMMA_LUT_BYPASS_EN adds a per-beat bypass input that passes pixels through unchanged.
//   state | meaning
//   INIT  | filling both banks, one address per cycle; input stalled
//   RUN   | streaming; cfg writes go to the shadow bank
//   PEND  | commit requested; swap banks on the next accepted SOF beat
module gamma_lut_ctrl
    import gamma_pkg::*;
#(
    parameter int PIX_W         = PIX_W_DEFAULT,
    parameter int INIT_IDENTITY = 1
) (
    input  logic               clk,
    input  logic               rst,
`ifdef GAMMA_LUT_BYPASS_EN
    input  logic               bypass,
`endif
    input  logic               s_tvalid,
    output logic               s_tready,
    input  logic [3*PIX_W-1:0] s_tdata,
    input  logic               s_tuser,
    input  logic               s_tlast,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic [3*PIX_W-1:0] m_tdata,
    output logic               m_tuser,
    output logic               m_tlast,
    input  logic               cfg_we,
    input  logic [PIX_W-1:0]   cfg_addr,
    input  logic [PIX_W-1:0]   cfg_data,
    input  logic               cfg_commit,
    output logic               cfg_busy,
    output logic               active_bank
);

    localparam logic [PIX_W-1:0] LAST_ADDR = {PIX_W{1'b1}};

    state_t             state;
    logic [PIX_W-1:0]   init_addr;
    logic               accept;
    logic               swap_now;
    logic               rd_bank;
    logic [1:0]         wr_en;
    logic [PIX_W-1:0]   wr_addr;
    logic [PIX_W-1:0]   wr_data;
    logic [PIX_W-1:0]   lut_r;
    logic [PIX_W-1:0]   lut_g;
    logic [PIX_W-1:0]   lut_b;
    logic [3*PIX_W-1:0] next_pix;

    assign s_tready = (state != INIT) && (!m_tvalid || m_tready);
    assign accept   = s_tvalid && s_tready;
    assign cfg_busy = (state != RUN);

    // The SOF beat that triggers the swap already reads from the new bank
    assign swap_now = (state == PEND) && accept && s_tuser;
    assign rd_bank  = active_bank ^ swap_now;

    always_comb begin
        wr_en   = 2'b00;
        wr_addr = cfg_addr;
        wr_data = cfg_data;
        case (state)
            INIT: begin
                wr_en   = 2'b11;
                wr_addr = init_addr;
                wr_data = (INIT_IDENTITY != 0) ? init_addr : '0;
            end
            RUN: begin
                if (cfg_we) wr_en = active_bank ? 2'b01 : 2'b10;
            end
            default: ;
        endcase
    end

    gamma_lut_bank #(.PIX_W(PIX_W)) u_bank (
        .clk       (clk),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_bank   (rd_bank),
        .rd_addr_r (s_tdata[3*PIX_W-1:2*PIX_W]),
        .rd_addr_g (s_tdata[2*PIX_W-1:PIX_W]),
        .rd_addr_b (s_tdata[PIX_W-1:0]),
        .rd_data_r (lut_r),
        .rd_data_g (lut_g),
        .rd_data_b (lut_b)
    );

`ifdef GAMMA_LUT_BYPASS_EN
    assign next_pix = bypass ? s_tdata : {lut_r, lut_g, lut_b};
`else
    assign next_pix = {lut_r, lut_g, lut_b};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT;
            init_addr   <= '0;
            active_bank <= 1'b0;
            m_tvalid    <= 1'b0;
            m_tdata     <= '0;
            m_tuser     <= 1'b0;
            m_tlast     <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    init_addr <= init_addr + 1'b1;
                    if (init_addr == LAST_ADDR) state <= RUN;
                end
                RUN: begin
                    if (cfg_commit) state <= PEND;
                end
                PEND: begin
                    if (swap_now) begin
                        active_bank <= ~active_bank;
                        state       <= RUN;
                    end
                end
                default: state <= INIT;
            endcase

            if (accept) begin
                m_tvalid <= 1'b1;
                m_tdata  <= next_pix;
                m_tuser  <= s_tuser;
                m_tlast  <= s_tlast;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gamma_lut_ctrl.sv
// Scoreboard bench for gamma_lut_ctrl; exercises GAMMA_LUT_BYPASS_EN when that macro is defined.
`timescale 1ns/1ps
module tb_gamma_lut_ctrl;
    import gamma_pkg::*;

    logic        clk;
    logic        rst;
    logic        bypass_i;
    logic        s_tvalid, s_tready, s_tuser, s_tlast;
    logic [23:0] s_tdata;
    logic        m_tvalid, m_tready, m_tuser, m_tlast;
    logic [23:0] m_tdata;
    logic        cfg_we, cfg_commit, cfg_busy, active_bank;
    logic [7:0]  cfg_addr, cfg_data;

    int tests = 0;
    int fails = 0;
    logic rand_ready;

    // reference model: tables as plain arrays, swap = exchange of contents
    logic [7:0]  cur_lut [256];
    logic [7:0]  nxt_lut [256];
    logic [7:0]  tmp_lut [256];
    logic        m_pending, m_init, m_bank;
    logic [25:0] sb_q [$];

    gamma_lut_ctrl dut (
        .clk         (clk),
        .rst         (rst),
`ifdef GAMMA_LUT_BYPASS_EN
        .bypass      (bypass_i),
`endif
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tdata     (s_tdata),
        .s_tuser     (s_tuser),
        .s_tlast     (s_tlast),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tdata     (m_tdata),
        .m_tuser     (m_tuser),
        .m_tlast     (m_tlast),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_commit  (cfg_commit),
        .cfg_busy    (cfg_busy),
        .active_bank (active_bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) begin
            cur_lut[i] = 8'(i);
            nxt_lut[i] = 8'(i);
        end
        m_pending = 1'b0;
        m_init    = 1'b1;
        m_bank    = 1'b0;
    endfunction

    function automatic void model_accept(logic [23:0] d, logic u, logic l);
        logic [23:0] e;
        if (m_pending && u) begin
            tmp_lut   = cur_lut;
            cur_lut   = nxt_lut;
            nxt_lut   = tmp_lut;
            m_pending = 1'b0;
            m_bank    = ~m_bank;
        end
        if (bypass_i) e = d;
        else e = {cur_lut[d[23:16]], cur_lut[d[15:8]], cur_lut[d[7:0]]};
        sb_q.push_back({u, l, e});
    endfunction

    initial begin
        m_tready = 1'b1;
        forever begin
            @(negedge clk);
            m_tready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // monitor: pops expected beats on each output handshake, checks hold while stalled
    initial begin
        logic        hold_v;
        logic [25:0] hold_d;
        logic [25:0] e;
        hold_v = 1'b0;
        hold_d = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                sb_q.delete();
                hold_v = 1'b0;
            end else begin
                if (hold_v)
                    check("stall_hold", {5'd0, m_tvalid, m_tuser, m_tlast, m_tdata}, {5'd0, 1'b1, hold_d});
                if (m_tvalid && m_tready) begin
                    if (sb_q.size() == 0) begin
                        check("sb_unexpected_beat", {8'd0, m_tdata}, 32'hFFFF_FFFF);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_data", {8'd0, m_tdata}, {8'd0, e[23:0]});
                        check("sb_sideband", {30'd0, m_tuser, m_tlast}, {30'd0, e[25:24]});
                    end
                end
                hold_v = m_tvalid && !m_tready;
                hold_d = {m_tuser, m_tlast, m_tdata};
            end
        end
    end

    task automatic send_beat(input logic [23:0] d, input logic u, input logic l);
        int n = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        #1;
        while (!s_tready && n < 2000) begin
            n++;
            @(negedge clk);
            #1;
        end
        if (s_tready) model_accept(d, u, l);
        else check("accept_timeout", 32'(n), 32'd0);
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [7:0] v);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = v;
        if (!m_pending && !m_init) nxt_lut[a] = v;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic cfg_commit_pulse();
        cfg_commit = 1'b1;
        if (!m_init) m_pending = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
    endtask

    task automatic check_status(string nm);
        #1;
        check({nm, "_busy"}, {31'd0, cfg_busy}, {31'd0, m_pending | m_init});
        check({nm, "_bank"}, {31'd0, active_bank}, {31'd0, m_bank});
        @(negedge clk);
    endtask

    // release reset with a beat waiting; count stalled cycles during table fill
    task automatic release_and_init(input logic [23:0] d);
        int n = 0;
        rst      = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
        #1;
        while (!s_tready && n < 1000) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("init_stall_cycles", 32'(n), 32'(LUT_DEPTH));
        m_init = 1'b0;
        if (s_tready) model_accept(d, 1'b0, 1'b0);
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        bypass_i   = 1'b0;
        s_tvalid   = 1'b0;
        s_tdata    = '0;
        s_tuser    = 1'b0;
        s_tlast    = 1'b0;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_data   = '0;
        cfg_commit = 1'b0;
        rand_ready = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        #1;
        check("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("rst_m_tdata", {8'd0, m_tdata}, 32'd0);
        check("rst_m_side", {30'd0, m_tuser, m_tlast}, 32'd0);
        check("rst_bank", {31'd0, active_bank}, 32'd0);
        check("rst_busy", {31'd0, cfg_busy}, 32'd1);
        check("rst_s_tready", {31'd0, s_tready}, 32'd0);
        @(negedge clk);

        release_and_init(24'h1080FF);
        check_status("after_init");

        cfg_write(8'h80, 8'h4A);
        cfg_commit_pulse();
        check_status("pend");
        send_beat(24'h808080, 1'b0, 1'b0);
        check_status("pend_nonsof");
        send_beat(24'h808080, 1'b1, 1'b0);
        check_status("swapped");

        send_beat(24'h00FF01, 1'b1, 1'b1);
        check_status("sof_in_run");

        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (i % 200 == 50) begin
                for (int k = 0; k < 6; k++)
                    cfg_write(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                cfg_commit_pulse();
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send_beat(24'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
        end
        rand_ready = 1'b0;
        if (m_pending) send_beat(24'h123456, 1'b1, 1'b0);
        check_status("after_stream");

        cfg_write(8'h00, 8'h00);
        cfg_commit_pulse();
        cfg_write(8'h00, 8'hFF);
        send_beat(24'h000000, 1'b1, 1'b0);
        check_status("pend_write");

        cfg_write(8'h10, 8'h99);
        cfg_commit_pulse();
        send_beat(24'h101010, 1'b0, 1'b0);
        rst      = 1'b1;
        s_tvalid = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("midrst_bank", {31'd0, active_bank}, 32'd0);
        check("midrst_busy", {31'd0, cfg_busy}, 32'd1);
        model_reset();
        @(negedge clk);
        release_and_init(24'h10_4A_80);
        check_status("reinit");

`ifdef GAMMA_LUT_BYPASS_EN
        cfg_write(8'h33, 8'h77);
        cfg_commit_pulse();
        send_beat(24'h333333, 1'b1, 1'b0);
        bypass_i = 1'b1;
        send_beat(24'h333333, 1'b0, 1'b1);
        send_beat(24'h3300FF, 1'b0, 1'b0);
        bypass_i = 1'b0;
        send_beat(24'h333333, 1'b0, 1'b0);
        check_status("bypass");
`endif

        n = 0;
        while ((sb_q.size() != 0 || m_tvalid) && n < 100) begin
            n++;
            @(negedge clk);
        end
        #2;
        check("drain_queue_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
